// File: rtl/spi_sram_responder.sv
// SPI Mode-0 slave standing in for a 23LC512 SRAM (READ 0x03, WRITE 0x02, RDMR 0x05).
// All SPI pins are oversampled in the clk domain. A backdoor port preloads and inspects memory.
module spi_sram_responder #(
   parameter int unsigned MEM_BYTES   = 256,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  MODE_BYTE   = 8'h40
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_spi_clk,
   input  logic                         i_spi_cs_n,
   input  logic                         i_spi_mosi,
   output logic                         o_spi_miso,
   input  logic                         i_bd_we,
   input  logic [$clog2(MEM_BYTES)-1:0] i_bd_addr,
   input  logic [7:0]                   i_bd_wdata,
   output logic [7:0]                   o_bd_rdata,
   output logic                         o_busy,
   output logic                         o_cmd_err
);

   localparam int unsigned AW = $clog2(MEM_BYTES);

   typedef enum logic [2:0] {
      StIdle, StCmd, StAddr, StWrite, StRead, StMode, StIgnore
   } state_e;

   logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
   logic                   r_sclk_prev, r_cs_prev;

   state_e                 r_state;
   logic [3:0]             r_bit_cnt;
   logic [14:0]            r_shift_in;
   logic [7:0]             r_shift_out;
   logic [AW-1:0]          r_addr;
   logic                   r_is_read;
   logic                   r_miso;
   logic                   r_cmd_err;
   logic [7:0]             r_bd_rdata;
   logic [7:0]             r_mem [MEM_BYTES];

   logic          w_sclk, w_cs, w_mosi;
   logic          w_rise, w_fall, w_cs_fall, w_cs_rise;
   logic [7:0]    w_byte_in;
   logic [15:0]   w_addr_in;
   logic [AW-1:0] w_addr_new, w_addr_inc;
   logic          w_spi_we;
   logic          w_unused_addr_bits;

   assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs      = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
   assign w_rise    = w_sclk & ~r_sclk_prev;
   assign w_fall    = ~w_sclk & r_sclk_prev;
   assign w_cs_fall = ~w_cs & r_cs_prev;
   assign w_cs_rise = w_cs & ~r_cs_prev;

   assign w_byte_in  = {r_shift_in[6:0], w_mosi};
   assign w_addr_in  = {r_shift_in, w_mosi};
   // Address bits above the array size are dropped (address taken modulo MEM_BYTES)
   assign w_addr_new = w_addr_in[AW-1:0];
   assign w_addr_inc = r_addr + AW'(1);
   assign w_unused_addr_bits = ^w_addr_in;

   assign w_spi_we = (r_state == StWrite) && w_rise && (r_bit_cnt == 4'd7) && !w_cs_rise;

   assign o_spi_miso = r_miso;
   assign o_cmd_err  = r_cmd_err;
   assign o_bd_rdata = r_bd_rdata;
   assign o_busy     = ~w_cs;

   // Synchronize SPI pins and keep one extra sample for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '1;
         r_mosi_sync <= '0;
         r_sclk_prev <= 1'b0;
         r_cs_prev   <= 1'b1;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_spi_clk};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
         r_sclk_prev <= w_sclk;
         r_cs_prev   <= w_cs;
      end
   end

   // Command/address/data FSM; captures on SPI rise, drives MISO on SPI fall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StIdle;
         r_bit_cnt   <= '0;
         r_shift_in  <= '0;
         r_shift_out <= '0;
         r_addr      <= '0;
         r_is_read   <= 1'b0;
         r_miso      <= 1'b0;
         r_cmd_err   <= 1'b0;
      end else begin
         r_cmd_err <= 1'b0;
         if (w_cs_rise) begin
            // Deselect aborts everything, partial bytes included
            r_state   <= StIdle;
            r_bit_cnt <= '0;
            r_miso    <= 1'b0;
         end else begin
            unique case (r_state)
               StIdle: begin
                  r_miso <= 1'b0;
                  if (w_cs_fall) begin
                     r_state   <= StCmd;
                     r_bit_cnt <= '0;
                  end
               end
               StCmd: begin
                  if (w_rise) begin
                     r_shift_in <= {r_shift_in[13:0], w_mosi};
                     r_bit_cnt  <= r_bit_cnt + 4'd1;
                     if (r_bit_cnt == 4'd7) begin
                        r_bit_cnt <= '0;
                        case (w_byte_in)
                           8'h03: begin
                              r_state   <= StAddr;
                              r_is_read <= 1'b1;
                           end
                           8'h02: begin
                              r_state   <= StAddr;
                              r_is_read <= 1'b0;
                           end
                           8'h05: begin
                              r_state     <= StMode;
                              r_shift_out <= MODE_BYTE;
                           end
                           default: begin
                              r_state   <= StIgnore;
                              r_cmd_err <= 1'b1;
                           end
                        endcase
                     end
                  end
               end
               StAddr: begin
                  if (w_rise) begin
                     r_shift_in <= {r_shift_in[13:0], w_mosi};
                     r_bit_cnt  <= r_bit_cnt + 4'd1;
                     if (r_bit_cnt == 4'd15) begin
                        r_bit_cnt <= '0;
                        r_addr    <= w_addr_new;
                        if (r_is_read) begin
                           r_state     <= StRead;
                           r_shift_out <= r_mem[w_addr_new];
                        end else begin
                           r_state <= StWrite;
                        end
                     end
                  end
               end
               StWrite: begin
                  if (w_rise) begin
                     r_shift_in <= {r_shift_in[13:0], w_mosi};
                     r_bit_cnt  <= r_bit_cnt + 4'd1;
                     if (r_bit_cnt == 4'd7) begin
                        r_bit_cnt <= '0;
                        r_addr    <= w_addr_inc;
                     end
                  end
               end
               StRead: begin
                  if (w_rise) begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                     if (r_bit_cnt == 4'd7) begin
                        // Preload late so backdoor writes to upcoming bytes are seen
                        r_bit_cnt   <= '0;
                        r_addr      <= w_addr_inc;
                        r_shift_out <= r_mem[w_addr_inc];
                     end
                  end else if (w_fall) begin
                     r_miso      <= r_shift_out[7];
                     r_shift_out <= {r_shift_out[6:0], 1'b0};
                  end
               end
               StMode: begin
                  if (w_rise) begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                     if (r_bit_cnt == 4'd7) begin
                        r_bit_cnt   <= '0;
                        r_shift_out <= MODE_BYTE;
                     end
                  end else if (w_fall) begin
                     r_miso      <= r_shift_out[7];
                     r_shift_out <= {r_shift_out[6:0], 1'b0};
                  end
               end
               StIgnore: begin
                  r_miso <= 1'b0;
               end
               default: begin
                  r_state <= StIdle;
               end
            endcase
         end
      end
   end

   // Memory array (not reset); an SPI commit beats a backdoor write to the same byte
   always_ff @(posedge clk) begin
      if (w_spi_we) begin
         r_mem[r_addr] <= w_byte_in;
      end
      if (i_bd_we && !(w_spi_we && (i_bd_addr == r_addr))) begin
         r_mem[i_bd_addr] <= i_bd_wdata;
      end
   end

   // Backdoor read port, one cycle latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bd_rdata <= '0;
      end else begin
         r_bd_rdata <= r_mem[i_bd_addr];
      end
   end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed bench for spi_sram_responder: SPI master tasks plus backdoor access.
module tb_spi_sram_responder;

   localparam int HALF = 6;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       spi_clk, spi_cs_n, spi_mosi, spi_miso;
   logic       bd_we;
   logic [7:0] bd_addr, bd_wdata, bd_rdata;
   logic       busy, cmd_err;

   int n_checks = 0;
   int n_fail   = 0;
   int n_err_pulses = 0;

   logic [7:0] rx;
   int         err_before;

   spi_sram_responder #(
      .MEM_BYTES  (256),
      .SYNC_STAGES(2),
      .MODE_BYTE  (8'h40)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_spi_clk (spi_clk),
      .i_spi_cs_n(spi_cs_n),
      .i_spi_mosi(spi_mosi),
      .o_spi_miso(spi_miso),
      .i_bd_we   (bd_we),
      .i_bd_addr (bd_addr),
      .i_bd_wdata(bd_wdata),
      .o_bd_rdata(bd_rdata),
      .o_busy    (busy),
      .o_cmd_err (cmd_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (cmd_err) n_err_pulses <= n_err_pulses + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rxd);
      rxd = '0;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = tx[7-i];
         repeat (HALF) @(negedge clk);
         spi_clk = 1'b1;
         rxd = {rxd[6:0], spi_miso};
         repeat (HALF) @(negedge clk);
         spi_clk = 1'b0;
      end
   endtask

   task automatic cs_low();
      spi_cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic cs_high();
      repeat (HALF) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      bd_we = 1'b1; bd_addr = a; bd_wdata = d;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   task automatic bd_read(input logic [7:0] a, output logic [7:0] d);
      @(negedge clk);
      bd_addr = a;
      @(negedge clk);
      d = bd_rdata;
   endtask

   initial begin
      rst_n = 1'b0; spi_clk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
      bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
      repeat (3) @(negedge clk);
      check("reset_miso", 32'(spi_miso), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_cmd_err", 32'(cmd_err), 32'd0);
      check("reset_bd_rdata", 32'(bd_rdata), 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Backdoor preload then SPI READ
      bd_write(8'h10, 8'hA5);
      bd_read(8'h10, rx);
      check("bd_readback_10", 32'(rx), 32'hA5);
      err_before = n_err_pulses;
      cs_low();
      check("busy_in_frame", 32'(busy), 32'd1);
      spi_xfer(8'h03, 8, rx);
      spi_xfer(8'h00, 8, rx);
      spi_xfer(8'h10, 8, rx);
      spi_xfer(8'hFF, 8, rx);
      check("read_10", 32'(rx), 32'hA5);
      cs_high();
      check("busy_after_frame", 32'(busy), 32'd0);
      check("miso_idle", 32'(spi_miso), 32'd0);
      check("read_no_cmd_err", 32'(n_err_pulses - err_before), 32'd0);

      // SPI WRITE of four sequential bytes
      cs_low();
      spi_xfer(8'h02, 8, rx);
      spi_xfer(8'h00, 8, rx);
      spi_xfer(8'h20, 8, rx);
      spi_xfer(8'hDE, 8, rx);
      spi_xfer(8'hAD, 8, rx);
      spi_xfer(8'hBE, 8, rx);
      spi_xfer(8'hEF, 8, rx);
      cs_high();
      bd_read(8'h20, rx); check("write_20", 32'(rx), 32'hDE);
      bd_read(8'h21, rx); check("write_21", 32'(rx), 32'hAD);
      bd_read(8'h22, rx); check("write_22", 32'(rx), 32'hBE);
      bd_read(8'h23, rx); check("write_23", 32'(rx), 32'hEF);

      // Address wrap on write, then read with upper address bit masked
      cs_low();
      spi_xfer(8'h02, 8, rx);
      spi_xfer(8'h00, 8, rx);
      spi_xfer(8'hFF, 8, rx);
      spi_xfer(8'h11, 8, rx);
      spi_xfer(8'h22, 8, rx);
      cs_high();
      bd_read(8'hFF, rx); check("wrap_write_ff", 32'(rx), 32'h11);
      bd_read(8'h00, rx); check("wrap_write_00", 32'(rx), 32'h22);
      cs_low();
      spi_xfer(8'h03, 8, rx);
      spi_xfer(8'h01, 8, rx);
      spi_xfer(8'hFF, 8, rx);
      spi_xfer(8'h00, 8, rx); check("wrap_read_0", 32'(rx), 32'h11);
      spi_xfer(8'h00, 8, rx); check("wrap_read_1", 32'(rx), 32'h22);
      cs_high();

      // Abort after 5 data bits: no write
      bd_write(8'h30, 8'h5A);
      cs_low();
      spi_xfer(8'h02, 8, rx);
      spi_xfer(8'h00, 8, rx);
      spi_xfer(8'h30, 8, rx);
      spi_xfer(8'hC3, 5, rx);
      cs_high();
      check("abort_busy", 32'(busy), 32'd0);
      bd_read(8'h30, rx); check("abort_mem_30", 32'(rx), 32'h5A);

      // Reset pulse in the middle of a READ
      bd_write(8'h50, 8'hFF);
      cs_low();
      spi_xfer(8'h03, 8, rx);
      spi_xfer(8'h00, 8, rx);
      spi_xfer(8'h50, 8, rx);
      spi_xfer(8'h00, 3, rx);
      check("mid_read_miso_high", 32'(spi_miso), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_mid_read_miso", 32'(spi_miso), 32'd0);
      check("rst_mid_read_busy", 32'(busy), 32'd0);
      spi_cs_n = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      bd_read(8'h20, rx); check("mem_kept_after_rst", 32'(rx), 32'hDE);

      // Unsupported opcode
      err_before = n_err_pulses;
      cs_low();
      spi_xfer(8'h9F, 8, rx);
      for (int b = 0; b < 3; b++) begin
         spi_xfer(8'hFF, 8, rx);
         check($sformatf("ignore_miso_%0d", b), 32'(rx), 32'h00);
      end
      cs_high();
      check("bad_op_one_pulse", 32'(n_err_pulses - err_before), 32'd1);
      cs_low();
      spi_xfer(8'h03, 8, rx);
      spi_xfer(8'h00, 8, rx);
      spi_xfer(8'h10, 8, rx);
      spi_xfer(8'h00, 8, rx);
      check("read_after_bad_op", 32'(rx), 32'hA5);
      cs_high();

      // RDMR
      cs_low();
      spi_xfer(8'h05, 8, rx);
      spi_xfer(8'h00, 8, rx); check("rdmr_0", 32'(rx), 32'h40);
      spi_xfer(8'h00, 8, rx); check("rdmr_1", 32'(rx), 32'h40);
      cs_high();

      // Backdoor write collides with SPI commit to 0x40
      cs_low();
      spi_xfer(8'h02, 8, rx);
      spi_xfer(8'h00, 8, rx);
      spi_xfer(8'h40, 8, rx);
      spi_xfer(8'h77, 7, rx);
      spi_mosi = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b1;
      // Synchronized rise is seen two clk later; commit lands on the third posedge
      repeat (2) @(negedge clk);
      bd_we = 1'b1; bd_addr = 8'h40; bd_wdata = 8'h33;
      @(negedge clk);
      bd_we = 1'b0;
      repeat (HALF - 3) @(negedge clk);
      spi_clk = 1'b0;
      cs_high();
      bd_read(8'h40, rx); check("collision_spi_wins", 32'(rx), 32'h77);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
